sqrt_result_pack: RTL
=====================

Name: sqrt_result_pack

Overview:
- Downstream consumer of the iterative square-root stage.
- Captures each finished result (sign, 7-bit signed exponent, 11-bit mantissa with hidden bit, special flags) and packs it into IEEE-754 binary16.
- Buffers packed words in a small FIFO and presents them on a valid/ready output port, because the sqrt stage has no backpressure.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, at least 2.
- AW, 1, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- it_valid  input  1  sqrt stage busy/valid flag.
- result  input  1  sqrt stage result-ready flag.
- sign_in  input  1  result sign.
- exp_in  input  7  signed unbiased exponent; -15 encodes zero/subnormal, 16 encodes special.
- mant_in  input  11  mantissa; bit 10 is the hidden bit.
- is_nan_in  input  1  result is NaN.
- is_pinf_in  input  1  result is +Inf.
- is_ninf_in  input  1  result is -Inf (never produced by sqrt; packed as NaN).
- flush  input  1  synchronous FIFO clear.
- out_ready  input  1  consumer accepts the head word.
- out_valid  output  1  FIFO not empty.
- out_data  output  16  binary16 word at the FIFO head; 0 when empty.
- level  output  AW+1  current FIFO occupancy.
- overflow  output  1  sticky: a capture was dropped because the FIFO was full.
- range_err  output  1  sticky: an out-of-range exponent was saturated.

Behaviour:
- Reset (rst_n low, asynchronous): pointers, level, storage, out_valid, out_data, overflow and range_err all go to 0. Reset mid-transfer discards everything.
- Capture: capture = result & it_valid, sampled each cycle.
  - One capture per operation.
  - A held result with it_valid low (idle special hold) is ignored.
- Packing (combinational on the inputs, written into the FIFO at capture), in priority order:
  1. is_nan_in or is_ninf_in -> {sign_in, 5'h1F, 1'b1, mant_in[8:0]} (quiet NaN).
  2. is_pinf_in -> 16'h7C00.
  3. exp_in == -15 -> {sign_in, 5'h00, mant_in[9:0]}.
  4. exp_in > 15 -> {sign_in, 15'h7C00}; set range_err.
  5. exp_in < -15 -> {sign_in, 15'h0000}; set range_err.
  6. Otherwise -> {sign_in, (exp_in+15)[4:0], mant_in[9:0]}. The biased exponent is computed at 7 bits, then truncated.
- FIFO:
  - push = capture & ~flush; pop = out_valid & out_ready & ~flush.
  - Pointers wrap modulo DEPTH; level counts 0..DEPTH.
- Latency: a capture in cycle N into an empty FIFO gives out_valid=1 and the packed out_data in cycle N+1. There is no combinational path from the inputs to the outputs.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_valid hold.
- Full (level==DEPTH):
  - push without pop -> word dropped, overflow set, level unchanged.
  - push with pop in the same cycle -> both happen, level stays DEPTH, no overflow.
- Empty: pop is impossible because out_valid=0. push-only -> level 1.
- Simultaneous push and pop with level 1: the new word becomes the head next cycle, level stays 1.
- flush: pointers and level go to 0 next cycle; a capture in the same cycle is discarded (not counted as overflow). Sticky flags are cleared only by reset.

Test Plan:
1. Reset release, no captures -> out_valid=0, out_data=16'h0000, level=0, overflow=0, range_err=0.
2. Normal result: capture with sign_in=0, exp_in=1, mant_in=11'h5A8, out_ready=1 -> next cycle out_valid=1, out_data=16'h41A8; following cycle out_valid=0.
3. Special results, one cycle apart:
   - is_pinf_in -> 16'h7C00.
   - is_nan_in with sign_in=1, mant_in=11'h600 -> 16'hFE00.
   - exp_in=-15, mant_in=0, sign_in=1 -> 16'h8000.
   - result held high with it_valid=0 for 5 cycles -> no extra pushes.
4. Backpressure with DEPTH=2, out_ready=0: three captures (exp 0/1/2, mant 11'h400) -> level=2, overflow=1, head=16'h3C00. Then out_ready=1 -> 16'h3C00, then 16'h4000; the third word is never output.
5. Full with simultaneous capture and pop -> level stays 2, no overflow, output order preserved.
6. exp_in=20 -> 16'h7C00 with range_err=1. flush asserted with 2 words queued -> next cycle out_valid=0, level=0. rst_n pulsed low mid-queue -> outputs clear immediately, asynchronously.

Source files
------------

// File: rtl/sqrt_result_pack_if.sv
// Bundle for the sqrt result capture inputs and the packed-word valid/ready output.
// The master modport belongs to the producer/consumer side and the slave modport to the packer.
interface sqrt_result_pack_if #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
);
    logic          it_valid;
    logic          result;
    logic          sign_in;
    logic [6:0]    exp_in;
    logic [10:0]   mant_in;
    logic          is_nan_in;
    logic          is_pinf_in;
    logic          is_ninf_in;
    logic          flush;
    logic          out_ready;
    logic          out_valid;
    logic [15:0]   out_data;
    logic [AW:0]   level;
    logic          overflow;
    logic          range_err;

    modport master (
        output it_valid, result, sign_in, exp_in, mant_in,
               is_nan_in, is_pinf_in, is_ninf_in, flush, out_ready,
        input  out_valid, out_data, level, overflow, range_err
    );

    modport slave (
        input  it_valid, result, sign_in, exp_in, mant_in,
               is_nan_in, is_pinf_in, is_ninf_in, flush, out_ready,
        output out_valid, out_data, level, overflow, range_err
    );
endinterface

// File: rtl/sqrt_result_pack.sv
// Captures finished sqrt results, packs them into binary16 and queues them in a
// small FIFO behind a valid/ready port, since the sqrt stage cannot be stalled.
module sqrt_result_pack #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input logic               clk,
    input logic               rst_n,
    sqrt_result_pack_if.slave bus
);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic              w_capture;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_write;
    logic              w_out_valid;
    logic              w_range_hi;
    logic              w_range_lo;
    logic signed [6:0] w_exp;
    logic        [6:0] w_biased;
    logic       [15:0] w_packed;

    logic       [15:0] r_mem [DEPTH];
    logic     [AW-1:0] r_wr_ptr;
    logic     [AW-1:0] r_rd_ptr;
    logic       [AW:0] r_level;
    logic              r_overflow;
    logic              r_range_err;

    assign w_exp    = bus.exp_in;
    assign w_biased = bus.exp_in + 7'd15;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_range_hi = 1'b0;
        w_range_lo = 1'b0;
        w_packed   = '0;
        if (bus.is_nan_in || bus.is_ninf_in) begin
            w_packed = {bus.sign_in, 5'h1F, 1'b1, bus.mant_in[8:0]};
        end else if (bus.is_pinf_in) begin
            w_packed = 16'h7C00;
        end else if (w_exp == -7'sd15) begin
            w_packed = {bus.sign_in, 5'h00, bus.mant_in[9:0]};
        end else if (w_exp > 7'sd15) begin
            w_packed   = {bus.sign_in, 15'h7C00};
            w_range_hi = 1'b1;
        end else if (w_exp < -7'sd15) begin
            w_packed   = {bus.sign_in, 15'h0000};
            w_range_lo = 1'b1;
        end else begin
            w_packed = {bus.sign_in, w_biased[4:0], bus.mant_in[9:0]};
        end
    end

    // A held result with it_valid low is the idle special hold, not a new operation.
    assign w_capture   = bus.result & bus.it_valid;
    assign w_out_valid = (r_level != '0);
    assign w_full      = (r_level == FULL_LEVEL);
    assign w_push      = w_capture & ~bus.flush;
    assign w_pop       = w_out_valid & bus.out_ready & ~bus.flush;
    assign w_write     = w_push & (~w_full | w_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
                if (w_write && !w_pop)      r_level <= r_level + (AW + 1)'(1);
                else if (!w_write && w_pop) r_level <= r_level - (AW + 1)'(1);
            end
            if (w_push && w_full && !w_pop)            r_overflow  <= 1'b1;
            if (w_capture && (w_range_hi || w_range_lo)) r_range_err <= 1'b1;
        end
    end

    // NOTE: storage is reset too, so nothing stale can ever appear on out_data after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_write) begin
            r_mem[r_wr_ptr] <= w_packed;
        end
    end

    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign bus.level     = r_level;
    assign bus.overflow  = r_overflow;
    assign bus.range_err = r_range_err;
endmodule
